alu_mdu_seq: RTL and testbench
==============================

Name: alu_mdu_seq

Overview:
- Parametrised successor to the single-cycle RV32I ALU.
- Executes the RV32I base arithmetic ops plus the RV32M multiply/divide ops behind a valid/ready handshake.
- Base ops complete in 1 cycle; MUL*/DIV*/REM* run an iterative XLEN-cycle datapath.
- Sits in the execute stage. The core stalls on in_ready/out_valid.

Parameters:
- XLEN, 32, operand/result width; power of two, >= 8.
- SHW, $clog2(XLEN), shift-amount width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request (state IDLE).
- op  in  5  operation code; see Behaviour.
- a  in  XLEN  operand A (rs1).
- b  in  XLEN  operand B (rs2/imm).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  XLEN  operation result.
- br_eq  out  1  a == b, from the captured operands.
- br_lt  out  1  signed a < b, from the captured operands.
- br_ltu  out  1  unsigned a < b, from the captured operands.
- busy  out  1  high in BUSY state.

Behaviour:
- Op codes:
  - ADD=1, SUB=2, AND=3, OR=4, XOR=5, SLL=6, SRL=7, SRA=8, SLT=9, SLTU=10.
  - MUL=11, MULH=12, MULHSU=13, MULHU=14, DIV=15, DIVU=16, REM=17, REMU=18.
  - Any other code: result 0, latency 1.
- Reset values: state IDLE, in_ready=1, out_valid=0, busy=0, result=0, br_*=0. Internal accumulators are cleared.
- FSM states IDLE, BUSY, DONE. Transfers:
  - Accept when in_valid && in_ready; operands and op are registered.
  - Output completes when out_valid && out_ready.
- IDLE:
  - On accept of a base op, an unknown op, or a DIV/REM special case: compute, load result/br_*, go to DONE. out_valid rises next cycle (latency 1).
  - On accept of a MUL* op or a normal DIV*/REM* op: go to BUSY with counter=XLEN-1.
- BUSY:
  - One iteration per cycle.
  - Counter decrements each cycle. At counter==0, load result and go to DONE.
  - Latency from accept to out_valid is XLEN+1 cycles.
  - in_ready=0 throughout.
- DONE:
  - out_valid=1. result and br_* stay stable until the output transfer.
  - On out_ready, go to IDLE next cycle.
  - in_ready is high only in IDLE, so there is no same-cycle accept in DONE.
  - Minimum issue interval is 2 cycles for base ops and XLEN+2 cycles for M ops.
- Shifts use b[SHW-1:0]. SRA is arithmetic.
- SLT/SLTU produce a zero-extended 0/1.
- br_eq/br_lt/br_ltu compare the captured a and b directly, not the result. They are valid with out_valid for every op.
- Multiply:
  - Shift-add over 2*XLEN-bit product, operands taken as magnitudes, with sign correction at the end.
  - MUL returns the low XLEN bits.
  - MULH returns the high XLEN bits with both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU: both unsigned.
- Divide:
  - Restoring division, one quotient bit per cycle, on magnitudes.
  - Quotient sign = sign(a) XOR sign(b). Remainder takes the sign of a.
- Divide special cases, latency 1, no BUSY:
  - b==0: DIV/DIVU give all-ones; REM/REMU give a.
  - Signed a==most-negative and b==-1: DIV gives a; REM gives 0.
- Reset asserted mid-operation aborts immediately to reset values. No result is emitted.
- Inputs are ignored while in_ready=0. Operands may change after accept without effect.

Test Plan:
- Base ops, XLEN=32:
  - ADD a=0x7FFFFFFF, b=1 -> result 0x80000000, out_valid 1 cycle after accept.
  - SRA a=0x80000000, b=0x24 -> 0xF8000000.
  - SLT a=0xFFFFFFFF, b=1 -> 1, br_lt=1, br_ltu=0.
- Multiply:
  - MUL a=0xFFFFFFFF(-1), b=5 -> 0xFFFFFFFB.
  - MULH on the same operands -> 0xFFFFFFFF.
  - MULHU on the same operands -> 0x00000004.
  - Each with out_valid exactly 33 cycles after accept and busy high 32 cycles.
- Divide:
  - DIV a=-7, b=2 -> 0xFFFFFFFD (-3).
  - REM a=-7, b=2 -> 0xFFFFFFFF (-1).
  - DIVU a=100, b=7 -> 14.
  - REMU a=100, b=7 -> 2.
- Special cases:
  - DIV a=5, b=0 -> 0xFFFFFFFF.
  - REM a=5, b=0 -> 5.
  - DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000.
  - REM a=0x80000000, b=0xFFFFFFFF -> 0.
  - All with latency 1.
- Backpressure: hold out_ready=0 for 10 cycles after a MUL completes -> result/out_valid stable, in_ready=0. Raise out_ready -> IDLE next cycle, then in_ready=1.
- Reset mid-op: assert rst at BUSY cycle 10 of a DIVU -> out_valid=0, in_ready=1, busy=0 immediately. Next ADD 2+3 -> 5 with no stale result.

Source files
------------

// File: rtl/alu_mdu_seq.sv
// RV32I ALU plus iterative RV32M multiply/divide.
// Valid/ready handshake; base ops in 1 cycle, M ops in XLEN+1.
module alu_mdu_seq #(
  parameter int XLEN = 32,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            br_eq,
  output logic            br_lt,
  output logic            br_ltu,
  output logic            busy
);

  localparam logic [4:0] OP_ADD    = 5'd1;
  localparam logic [4:0] OP_SUB    = 5'd2;
  localparam logic [4:0] OP_AND    = 5'd3;
  localparam logic [4:0] OP_OR     = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SLL    = 5'd6;
  localparam logic [4:0] OP_SRL    = 5'd7;
  localparam logic [4:0] OP_SRA    = 5'd8;
  localparam logic [4:0] OP_SLT    = 5'd9;
  localparam logic [4:0] OP_SLTU   = 5'd10;
  localparam logic [4:0] OP_MUL    = 5'd11;
  localparam logic [4:0] OP_MULH   = 5'd12;
  localparam logic [4:0] OP_MULHSU = 5'd13;
  localparam logic [4:0] OP_MULHU  = 5'd14;
  localparam logic [4:0] OP_DIV    = 5'd15;
  localparam logic [4:0] OP_DIVU   = 5'd16;
  localparam logic [4:0] OP_REM    = 5'd17;
  localparam logic [4:0] OP_REMU   = 5'd18;

  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state;

  logic [4:0]        op_q;
  logic              mul_q;
  logic [SHW-1:0]    cnt;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] mcand;
  logic [XLEN-1:0]   mplier;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   dvs;
  logic              neg_p;
  logic              neg_q;
  logic              neg_r;

  logic              is_mul;
  logic              is_div;
  logic              sgn_a;
  logic              sgn_b;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic              b_zero;
  logic              ovf;
  logic              div_spec;
  logic              start_mul;
  logic              start_div;
  logic [XLEN-1:0]   base_res;
  logic [XLEN-1:0]   imm_res;

  logic [2*XLEN-1:0] prod_nx;
  logic [2*XLEN-1:0] p_fin;
  logic [XLEN:0]     r_sh;
  logic              ge;
  logic [XLEN-1:0]   rem_nx;
  logic [XLEN-1:0]   quo_nx;
  logic [XLEN-1:0]   q_fin;
  logic [XLEN-1:0]   r_fin;
  logic [XLEN-1:0]   m_res;

  // Classify the incoming op and form operand magnitudes.
  always_comb begin
    is_mul = (op >= OP_MUL) && (op <= OP_MULHU);
    is_div = (op >= OP_DIV) && (op <= OP_REMU);
    sgn_a  = (op == OP_MUL) || (op == OP_MULH) ||
             (op == OP_MULHSU) || (op == OP_DIV) ||
             (op == OP_REM);
    sgn_b  = (op == OP_MUL) || (op == OP_MULH) ||
             (op == OP_DIV) || (op == OP_REM);
    a_neg  = sgn_a & a[XLEN-1];
    b_neg  = sgn_b & b[XLEN-1];
    a_mag  = a_neg ? -a : a;
    b_mag  = b_neg ? -b : b;
    b_zero = (b == '0);
    ovf    = ((op == OP_DIV) || (op == OP_REM)) &&
             (a == MIN_NEG) && (b == '1);
    div_spec  = is_div && (b_zero || ovf);
    start_mul = is_mul;
    start_div = is_div && !div_spec;
  end

  // Single-cycle results: base ops, unknown ops, divide corner cases.
  always_comb begin
    base_res = '0;
    case (op)
      OP_ADD:  base_res = a + b;
      OP_SUB:  base_res = a - b;
      OP_AND:  base_res = a & b;
      OP_OR:   base_res = a | b;
      OP_XOR:  base_res = a ^ b;
      OP_SLL:  base_res = a << b[SHW-1:0];
      OP_SRL:  base_res = a >> b[SHW-1:0];
      OP_SRA:  base_res = $signed(a) >>> b[SHW-1:0];
      OP_SLT:  base_res = {{(XLEN-1){1'b0}},
                           $signed(a) < $signed(b)};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, a < b};
      default: base_res = '0;
    endcase
    imm_res = base_res;
    if (is_div) begin
      if (b_zero)
        imm_res = ((op == OP_DIV) || (op == OP_DIVU)) ?
                  '1 : a;
      else
        imm_res = (op == OP_DIV) ? a : '0;
    end
  end

  // One shift-add step and one restoring-divide step.
  always_comb begin
    prod_nx = prod + (mplier[0] ? mcand : '0);
    p_fin   = neg_p ? -prod_nx : prod_nx;
    r_sh    = {rem, quo[XLEN-1]};
    ge      = (r_sh >= {1'b0, dvs});
    rem_nx  = ge ? (r_sh[XLEN-1:0] - dvs) : r_sh[XLEN-1:0];
    quo_nx  = {quo[XLEN-2:0], ge};
    q_fin   = neg_q ? -quo_nx : quo_nx;
    r_fin   = neg_r ? -rem_nx : rem_nx;
    m_res   = '0;
    case (op_q)
      OP_MUL:                 m_res = p_fin[XLEN-1:0];
      OP_MULH, OP_MULHSU,
      OP_MULHU:               m_res = p_fin[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:        m_res = q_fin;
      default:                m_res = r_fin;
    endcase
  end

  // Control FSM with registered handshake, result and branch flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      br_eq     <= 1'b0;
      br_lt     <= 1'b0;
      br_ltu    <= 1'b0;
      op_q      <= '0;
      mul_q     <= 1'b0;
      cnt       <= '0;
      prod      <= '0;
      mcand     <= '0;
      mplier    <= '0;
      quo       <= '0;
      rem       <= '0;
      dvs       <= '0;
      neg_p     <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q     <= op;
            br_eq    <= (a == b);
            br_lt    <= ($signed(a) < $signed(b));
            br_ltu   <= (a < b);
            in_ready <= 1'b0;
            unique case (1'b1)
              start_mul: begin
                mul_q  <= 1'b1;
                prod   <= '0;
                mcand  <= {{XLEN{1'b0}}, a_mag};
                mplier <= b_mag;
                neg_p  <= a_neg ^ b_neg;
                cnt    <= SHW'(XLEN-1);
                busy   <= 1'b1;
                state  <= BUSY;
              end
              start_div: begin
                mul_q <= 1'b0;
                quo   <= a_mag;
                rem   <= '0;
                dvs   <= b_mag;
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
                cnt   <= SHW'(XLEN-1);
                busy  <= 1'b1;
                state <= BUSY;
              end
              default: begin
                result    <= imm_res;
                out_valid <= 1'b1;
                state     <= DONE;
              end
            endcase
          end
        end
        BUSY: begin
          cnt <= cnt - SHW'(1);
          if (mul_q) begin
            prod   <= prod_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end else begin
            quo <= quo_nx;
            rem <= rem_nx;
          end
          if (cnt == '0) begin
            result    <= m_res;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed vector bench for alu_mdu_seq (XLEN=32).
// Table of ops plus backpressure and mid-op reset sequences.
module tb_alu_mdu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        br_eq;
  logic        br_lt;
  logic        br_ltu;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_mdu_seq #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .br_eq    (br_eq),
    .br_lt    (br_lt),
    .br_ltu   (br_ltu),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [7:0]  lat;
    logic [2:0]  br;
  } vec_t;

  vec_t tv[$];

  function automatic void add(
    input logic [4:0] o, input logic [31:0] x,
    input logic [31:0] y, input logic [31:0] r,
    input logic [7:0] l, input logic [2:0] f);
    vec_t v;
    v.op = o; v.a = x; v.b = y;
    v.res = r; v.lat = l; v.br = f;
    tv.push_back(v);
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic issue(input logic [4:0] o,
                       input logic [31:0] x,
                       input logic [31:0] y);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout in_ready stuck 0");
    end
    in_valid = 1'b1;
    op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 5'd1;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_done(output int lat,
                           output int bc);
    lat = 1;
    bc = 0;
    while (!out_valid && lat < 100) begin
      if (busy) bc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int lat;
    int bc;
    int ebc;
    issue(v.op, v.a, v.b);
    wait_done(lat, bc);
    ebc = (v.lat > 8'd1) ? 32 : 0;
    chk($sformatf("v%0d_res", i), result, v.res);
    chk($sformatf("v%0d_lat", i), 32'(lat),
        32'(v.lat));
    chk($sformatf("v%0d_busy", i), 32'(bc),
        32'(ebc));
    chk($sformatf("v%0d_br", i),
        {29'd0, br_eq, br_lt, br_ltu}, {29'd0, v.br});
    drain();
  endtask

  initial begin
    int lat;
    int bc;

    // br = {eq, lt, ltu}
    add(5'd1,  32'h7FFFFFFF, 32'h1, 32'h80000000, 1, 3'b000);
    add(5'd2,  32'h5, 32'h7, 32'hFFFFFFFE, 1, 3'b011);
    add(5'd3,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1, 3'b010);
    add(5'd4,  32'h12340000, 32'h5678, 32'h12345678, 1, 3'b000);
    add(5'd5,  32'hFFFF0000, 32'hFFFF0000, 32'h0, 1, 3'b100);
    add(5'd6,  32'h1, 32'h21, 32'h2, 1, 3'b011);
    add(5'd7,  32'h80000000, 32'h4, 32'h08000000, 1, 3'b010);
    add(5'd8,  32'h80000000, 32'h24, 32'hF8000000, 1, 3'b010);
    add(5'd9,  32'hFFFFFFFF, 32'h1, 32'h1, 1, 3'b010);
    add(5'd10, 32'hFFFFFFFF, 32'h1, 32'h0, 1, 3'b010);
    add(5'd0,  32'h3, 32'h3, 32'h0, 1, 3'b100);
    add(5'd31, 32'h1, 32'h2, 32'h0, 1, 3'b011);
    add(5'd11, 32'hFFFFFFFF, 32'h5, 32'hFFFFFFFB, 33, 3'b010);
    add(5'd12, 32'hFFFFFFFF, 32'h5, 32'hFFFFFFFF, 33, 3'b010);
    add(5'd14, 32'hFFFFFFFF, 32'h5, 32'h4, 33, 3'b010);
    add(5'd13, 32'hFFFFFFFF, 32'h5, 32'hFFFFFFFF, 33, 3'b010);
    add(5'd13, 32'h5, 32'hFFFFFFFF, 32'h4, 33, 3'b001);
    add(5'd11, 32'h12345678, 32'h10, 32'h23456780, 33, 3'b000);
    add(5'd15, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 33, 3'b010);
    add(5'd17, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 33, 3'b010);
    add(5'd16, 32'd100, 32'd7, 32'd14, 33, 3'b000);
    add(5'd18, 32'd100, 32'd7, 32'd2, 33, 3'b000);
    add(5'd15, 32'h7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33, 3'b001);
    add(5'd17, 32'h7, 32'hFFFFFFFE, 32'h1, 33, 3'b001);
    add(5'd16, 32'h80000000, 32'hFFFFFFFF, 32'h0, 33, 3'b011);
    add(5'd18, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, 3'b011);
    add(5'd15, 32'h5, 32'h0, 32'hFFFFFFFF, 1, 3'b000);
    add(5'd17, 32'h5, 32'h0, 32'h5, 1, 3'b000);
    add(5'd16, 32'h5, 32'h0, 32'hFFFFFFFF, 1, 3'b000);
    add(5'd18, 32'h5, 32'h0, 32'h5, 1, 3'b000);
    add(5'd15, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 3'b011);
    add(5'd17, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, 3'b011);

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_br", {29'd0, br_eq, br_lt, br_ltu}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < tv.size(); i++)
      run_vec(i, tv[i]);

    // Backpressure: result held while out_ready stays low.
    issue(5'd11, 32'hFFFFFFFF, 32'h5);
    wait_done(lat, bc);
    chk("bp_lat", 32'(lat), 32'd33);
    chk("bp_busy", 32'(bc), 32'd32);
    in_valid = 1'b1;
    op = 5'd1; a = 32'h1; b = 32'h1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_res_%0d", k), result,
          32'hFFFFFFFB);
      chk($sformatf("bp_ov_%0d", k),
          {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp_ir_%0d", k),
          {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_rel_ov", {31'd0, out_valid}, 32'd0);
    chk("bp_rel_ir", {31'd0, in_ready}, 32'd1);

    // Reset at BUSY cycle 10 of a DIVU.
    issue(5'd16, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_ov", {31'd0, out_valid}, 32'd0);
    chk("mid_ir", {31'd0, in_ready}, 32'd1);
    chk("mid_busy0", {31'd0, busy}, 32'd0);
    chk("mid_res", result, 32'd0);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_ov", {31'd0, out_valid}, 32'd0);
    begin
      vec_t v;
      v.op = 5'd1; v.a = 32'd2; v.b = 32'd3;
      v.res = 32'd5; v.lat = 8'd1; v.br = 3'b011;
      run_vec(99, v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
